// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   rx_state_e     : frame FSM states (PARITY exists only when UART_RX_PARITY_EN is defined)
//   PRESCALE_*     : the legal oversampling ratios
//   legal_prescale : maps any Prescale value onto a legal ratio (illegal -> 16)
// Configuration macro: UART_RX_PARITY_EN
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_e;
`endif

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
      default:                              return PRESCALE_16;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler -- 3-point majority sampler for one oversampled bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : synchronized serial line
//   edge_cnt   : position inside the current bit (0..P-1)
//   half       : P/2 for the frame's latched prescale
//   bit_val    : 2-of-3 majority of samples at P/2-1, P/2 and P/2+1
//   resolve    : high while edge_cnt == P/2+1, i.e. bit_val is final
module uart_rx_sampler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [5:0] edge_cnt,
  input  logic [4:0] half,
  output logic       bit_val,
  output logic       resolve
);

  logic [5:0] mid;
  logic       s0;
  logic       s1;

  assign mid = {1'b0, half};

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (edge_cnt == mid - 6'd1) s0 <= rx;
      if (edge_cnt == mid)        s1 <= rx;
    end
  end

  // The third sample is the live line value at P/2+1, so the majority is
  // available in the same cycle the FSM consumes it.
  assign resolve = (edge_cnt == mid + 6'd1);
  assign bit_val = (s0 & s1) | (s0 & rx) | (s1 & rx);

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame -- oversampled UART frame receiver.
//   clk, rst_n  : oversampling clock, asynchronous active-low reset
//   RX_IN       : serial line, idle high, asynchronous to clk
//   Prescale    : oversampling ratio (8/16/32; anything else behaves as 16)
//   PAR_EN      : parity bit present
//   PAR_TYP     : 0 = even, 1 = odd
//   P_DATA      : last good received word
//   Data_Valid  : one-cycle pulse per good frame
//   Par_Err     : one-cycle pulse on parity mismatch
//   Stp_Err     : one-cycle pulse when the stop bit reads 0
// Configuration macro: UART_RX_PARITY_EN (undefined: no parity support,
// PAR_EN/PAR_TYP ignored, Par_Err tied low).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic [1:0]            sync;
  logic                  rx_s;
  rx_state_e             state;
  logic [5:0]            edge_cnt;
  logic [5:0]            cfg_prescale;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  bit_val;
  logic                  resolve;
  logic                  bit_end;

`ifdef UART_RX_PARITY_EN
  logic cfg_par_en;
  logic cfg_par_typ;
  logic par_fail;
`else
  logic unused_cfg;
  assign unused_cfg = PAR_EN ^ PAR_TYP;
  assign Par_Err    = 1'b0;
`endif

  // NOTE: the synchronizer resets to 1 (idle line) so leaving reset can
  // never look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], RX_IN};
  end

  assign rx_s    = sync[1];
  assign bit_end = (edge_cnt == cfg_prescale - 6'd1);

  uart_rx_sampler u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx_s),
    .edge_cnt (edge_cnt),
    .half     (cfg_prescale[5:1]),
    .bit_val  (bit_val),
    .resolve  (resolve)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      cfg_prescale <= PRESCALE_16;
      P_DATA       <= '0;
      Data_Valid   <= 1'b0;
      Stp_Err      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      cfg_par_en   <= 1'b0;
      cfg_par_typ  <= 1'b0;
      par_fail     <= 1'b0;
      Par_Err      <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low every cycle, so a single assignment
      // below produces exactly a one-cycle pulse.
      Data_Valid <= 1'b0;
      Stp_Err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Par_Err    <= 1'b0;
`endif
      edge_cnt <= (state == IDLE || bit_end) ? 6'd0 : edge_cnt + 6'd1;

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rx_s) begin
            state        <= START;
            cfg_prescale <= legal_prescale(Prescale);
`ifdef UART_RX_PARITY_EN
            cfg_par_en   <= PAR_EN;
            cfg_par_typ  <= PAR_TYP;
            par_fail     <= 1'b0;
`endif
          end
        end
        START: begin
          // A start bit that reads high at its centre was a glitch.
          if (resolve && bit_val) state <= IDLE;
          else if (bit_end)       state <= DATA;
        end
        DATA: begin
          if (resolve) begin
            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + BW'(1);
          end
          if (bit_end && bit_cnt == BW'(DATA_WIDTH)) begin
`ifdef UART_RX_PARITY_EN
            state <= cfg_par_en ? PARITY : STOP;
`else
            state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (resolve && (bit_val != ((^shift_reg) ^ cfg_par_typ))) par_fail <= 1'b1;
          if (bit_end) state <= STOP;
        end
`endif
        STOP: begin
          // Leave at the stop-bit centre so a back-to-back start edge is seen.
          if (resolve) begin
            state   <= IDLE;
            Stp_Err <= !bit_val;
`ifdef UART_RX_PARITY_EN
            Par_Err    <= par_fail;
            Data_Valid <= bit_val && !par_fail;
            if (bit_val && !par_fail) P_DATA <= shift_reg;
`else
            Data_Valid <= bit_val;
            if (bit_val) P_DATA <= shift_reg;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame -- self-checking bench for uart_rx_frame.
// A serial driver builds frames bit by bit; a monitor counts output pulses
// and records received words; a frame-level reference model predicts pulse
// counts and P_DATA. Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_frame;
  import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       RX_IN    = 1'b1;
  logic [5:0] Prescale = 6'd16;
  logic       PAR_EN   = 1'b0;
  logic       PAR_TYP  = 1'b0;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       Par_Err;
  logic       Stp_Err;

  int vectors     = 0;
  int miscompares = 0;

  // Monitor state (written only by the monitor).
  int         dv_cnt = 0;
  int         pe_cnt = 0;
  int         se_cnt = 0;
  logic [7:0] rx_q[$];

  // Reference model state: last good word.
  logic [7:0] exp_pdata = 8'h00;

  always #5 clk = ~clk;

  uart_rx_frame #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Par_Err    (Par_Err),
    .Stp_Err    (Stp_Err)
  );

  always @(posedge clk) begin
    #2;
    if (Data_Valid === 1'b1) begin
      dv_cnt++;
      rx_q.push_back(P_DATA);
    end
    if (Par_Err === 1'b1) pe_cnt++;
    if (Stp_Err === 1'b1) se_cnt++;
  end

  function automatic int period(input logic [5:0] pre);
    return (pre == 6'd8 || pre == 6'd16 || pre == 6'd32) ? int'(pre) : 16;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge clk);
  endtask

  // par_ok=0 sends the wrong parity bit; scramble changes the config
  // inputs while data bits are on the line.
  task automatic send_frame(input logic [7:0] d, input logic [5:0] pre, input logic pen,
                            input logic ptyp, input logic par_ok, input logic stop,
                            input bit scramble);
    int p;
    p = period(pre);
    Prescale = pre;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    send_bit(1'b0, p);
    if (scramble) begin
      Prescale = 6'($urandom);
      PAR_EN   = 1'($urandom);
      PAR_TYP  = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    Prescale = pre;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    if (pen && PAR_BUILD) send_bit((^d) ^ ptyp ^ !par_ok, p);
    send_bit(stop, p);
    RX_IN = 1'b1;
  endtask

  // Frame-level expectations straight from the receive rules.
  task automatic model_frame(input logic [7:0] d, input logic pen, input logic par_ok,
                             input logic stop, output int e_dv, output int e_pe,
                             output int e_se);
    bit par_fail;
    par_fail = pen && PAR_BUILD && !par_ok;
    e_pe = par_fail ? 1 : 0;
    e_se = stop ? 0 : 1;
    e_dv = (stop && !par_fail) ? 1 : 0;
    if (e_dv == 1) exp_pdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({P_DATA, Data_Valid, Par_Err, Stp_Err} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got P_DATA=%h dv=%b pe=%b se=%b want all 0",
               P_DATA, Data_Valid, Par_Err, Stp_Err);
    end
    vectors++;
    if (dut.sync !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_sync: got %b want 11", dut.sync);
    end
    vectors++;
    if (dut.state !== IDLE || dut.edge_cnt !== 6'd0 || dut.bit_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_fsm: got state=%0d edge=%0d bit=%0d want 0/0/0",
               dut.state, dut.edge_cnt, dut.bit_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_p8_a5();
    int b_dv, b_pe, b_se, e_dv, e_pe, e_se;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    model_frame(8'hA5, 1'b0, 1'b1, 1'b1, e_dv, e_pe, e_se);
    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(24);
    vectors++;
    if (dv_cnt - b_dv !== e_dv || pe_cnt - b_pe !== e_pe || se_cnt - b_se !== e_se) begin
      miscompares++;
      $display("FAIL p8_a5_pulses: got dv=%0d pe=%0d se=%0d want dv=%0d pe=%0d se=%0d",
               dv_cnt - b_dv, pe_cnt - b_pe, se_cnt - b_se, e_dv, e_pe, e_se);
    end
    vectors++;
    if (P_DATA !== exp_pdata) begin
      miscompares++;
      $display("FAIL p8_a5_data: got %h want %h", P_DATA, exp_pdata);
    end
  endtask

  task automatic test_parity();
    int b_dv, b_pe, b_se, e_dv, e_pe, e_se;
    for (int k = 0; k < 2; k++) begin
      b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
      model_frame(8'h3C, 1'b1, (k == 0), 1'b1, e_dv, e_pe, e_se);
      send_frame(8'h3C, 6'd16, 1'b1, 1'b0, (k == 0), 1'b1, 1'b0);
      idle(48);
      vectors++;
      if (dv_cnt - b_dv !== e_dv || pe_cnt - b_pe !== e_pe || se_cnt - b_se !== e_se) begin
        miscompares++;
        $display("FAIL parity_%0d_pulses: got dv=%0d pe=%0d se=%0d want dv=%0d pe=%0d se=%0d",
                 k, dv_cnt - b_dv, pe_cnt - b_pe, se_cnt - b_se, e_dv, e_pe, e_se);
      end
      vectors++;
      if (P_DATA !== exp_pdata) begin
        miscompares++;
        $display("FAIL parity_%0d_data: got %h want %h", k, P_DATA, exp_pdata);
      end
    end
  endtask

  task automatic test_stop_err();
    int b_dv, b_pe, b_se, e_dv, e_pe, e_se;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    model_frame(8'h55, 1'b0, 1'b1, 1'b0, e_dv, e_pe, e_se);
    send_frame(8'h55, 6'd16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(48);
    vectors++;
    if (dv_cnt - b_dv !== e_dv || pe_cnt - b_pe !== e_pe || se_cnt - b_se !== e_se) begin
      miscompares++;
      $display("FAIL stop_err_pulses: got dv=%0d pe=%0d se=%0d want dv=%0d pe=%0d se=%0d",
               dv_cnt - b_dv, pe_cnt - b_pe, se_cnt - b_se, e_dv, e_pe, e_se);
    end
    vectors++;
    if (P_DATA !== exp_pdata) begin
      miscompares++;
      $display("FAIL stop_err_data: got %h want %h", P_DATA, exp_pdata);
    end
  endtask

  task automatic test_glitch();
    int b_dv, b_pe, b_se, e_dv, e_pe, e_se;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (3) @(negedge clk);
    RX_IN = 1'b1;
    idle(40);
    vectors++;
    if (dv_cnt != b_dv || pe_cnt != b_pe || se_cnt != b_se) begin
      miscompares++;
      $display("FAIL glitch_pulses: got dv=%0d pe=%0d se=%0d want 0/0/0",
               dv_cnt - b_dv, pe_cnt - b_pe, se_cnt - b_se);
    end
    vectors++;
    if (dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL glitch_state: got %0d want IDLE", dut.state);
    end
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    model_frame(8'h81, 1'b0, 1'b1, 1'b1, e_dv, e_pe, e_se);
    send_frame(8'h81, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(48);
    vectors++;
    if (dv_cnt - b_dv !== e_dv || pe_cnt - b_pe !== e_pe || se_cnt - b_se !== e_se
        || P_DATA !== exp_pdata) begin
      miscompares++;
      $display("FAIL glitch_next_frame: got dv=%0d pe=%0d se=%0d data=%h want dv=%0d pe=%0d se=%0d data=%h",
               dv_cnt - b_dv, pe_cnt - b_pe, se_cnt - b_se, P_DATA, e_dv, e_pe, e_se, exp_pdata);
    end
  endtask

  task automatic test_back_to_back();
    int b_dv, b_pe, b_se, b_q, e_dv0, e_dv1, e_pe, e_se;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt; b_q = rx_q.size();
    model_frame(8'h00, 1'b0, 1'b1, 1'b1, e_dv0, e_pe, e_se);
    model_frame(8'hFF, 1'b0, 1'b1, 1'b1, e_dv1, e_pe, e_se);
    send_frame(8'h00, 6'd32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 6'd32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(96);
    vectors++;
    if (dv_cnt - b_dv !== e_dv0 + e_dv1 || pe_cnt != b_pe || se_cnt != b_se) begin
      miscompares++;
      $display("FAIL b2b_pulses: got dv=%0d pe=%0d se=%0d want dv=%0d pe=0 se=0",
               dv_cnt - b_dv, pe_cnt - b_pe, se_cnt - b_se, e_dv0 + e_dv1);
    end
    vectors++;
    if (rx_q.size() < b_q + 2) begin
      miscompares++;
      $display("FAIL b2b_words: got %0d words want 2", rx_q.size() - b_q);
    end else if (rx_q[b_q] !== 8'h00 || rx_q[b_q+1] !== exp_pdata) begin
      miscompares++;
      $display("FAIL b2b_words: got %h,%h want 00,%h", rx_q[b_q], rx_q[b_q+1], exp_pdata);
    end
  endtask

  task automatic test_reset_mid();
    int b_dv, b_pe, b_se, e_dv, e_pe, e_se;
    logic [7:0] d;
    d = 8'hE7;
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(d[i], 16);
    RX_IN = d[4];
    idle(8);
    #2;
    rst_n = 1'b0;
    RX_IN = 1'b1;
    exp_pdata = 8'h00;
    #1;
    vectors++;
    if ({P_DATA, Data_Valid, Par_Err, Stp_Err} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got P_DATA=%h dv=%b pe=%b se=%b want all 0",
               P_DATA, Data_Valid, Par_Err, Stp_Err);
    end
    idle(3);
    rst_n = 1'b1;
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    idle(64);
    vectors++;
    if (dv_cnt != b_dv || pe_cnt != b_pe || se_cnt != b_se || P_DATA !== exp_pdata) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got dv=%0d pe=%0d se=%0d data=%h want 0/0/0 data=%h",
               dv_cnt - b_dv, pe_cnt - b_pe, se_cnt - b_se, P_DATA, exp_pdata);
    end
    b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
    model_frame(8'h12, 1'b0, 1'b1, 1'b1, e_dv, e_pe, e_se);
    send_frame(8'h12, 6'd16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(48);
    vectors++;
    if (dv_cnt - b_dv !== e_dv || pe_cnt - b_pe !== e_pe || se_cnt - b_se !== e_se
        || P_DATA !== exp_pdata) begin
      miscompares++;
      $display("FAIL reset_mid_frame: got dv=%0d pe=%0d se=%0d data=%h want dv=%0d pe=%0d se=%0d data=%h",
               dv_cnt - b_dv, pe_cnt - b_pe, se_cnt - b_se, P_DATA, e_dv, e_pe, e_se, exp_pdata);
    end
  endtask

  task automatic test_random();
    int b_dv, b_pe, b_se, e_dv, e_pe, e_se;
    logic [7:0] d;
    logic [5:0] pre;
    logic pen, ptyp, par_ok, stop;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       pre = 6'd8;
        1:       pre = 6'd16;
        2:       pre = 6'd32;
        default: pre = 6'($urandom);
      endcase
      pen    = 1'($urandom);
      ptyp   = 1'($urandom);
      par_ok = ($urandom_range(0, 3) != 0);
      stop   = ($urandom_range(0, 3) != 0);
      b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
      model_frame(d, pen, par_ok, stop, e_dv, e_pe, e_se);
      send_frame(d, pre, pen, ptyp, par_ok, stop, 1'b1);
      idle(3 * period(pre));
      vectors++;
      if (dv_cnt - b_dv !== e_dv || pe_cnt - b_pe !== e_pe || se_cnt - b_se !== e_se
          || P_DATA !== exp_pdata) begin
        miscompares++;
        $display("FAIL random_%0d (d=%h pre=%0d pen=%b typ=%b pok=%b stop=%b): got dv=%0d pe=%0d se=%0d data=%h want dv=%0d pe=%0d se=%0d data=%h",
                 n, d, pre, pen, ptyp, par_ok, stop, dv_cnt - b_dv, pe_cnt - b_pe,
                 se_cnt - b_se, P_DATA, e_dv, e_pe, e_se, exp_pdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_p8_a5();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
